// File: rtl/lsq_mem_stage.sv
// Data-memory access stage behind the LSQ: in-order request FIFO,
// fixed-latency word RAM, one completion per accepted request.
module lsq_mem_stage #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int LAT       = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_addr,
  input  logic        req_store,
  input  logic        req_fwd,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_data,
  output logic        resp_store,
  output logic        resp_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_addr  [DEPTH];
  logic [31:0] fifo_wdata [DEPTH];
  logic        fifo_store [DEPTH];
  logic        fifo_fwd   [DEPTH];
  logic [31:0] mem        [MEM_WORDS];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   cur_pc_q, cur_pc_d;
  logic [AW-1:0] cur_idx_q, cur_idx_d;
  logic          cur_store_q, cur_store_d;
  logic [31:0]   cur_wdata_q, cur_wdata_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          resp_store_q, resp_store_d;
  logic          resp_fault_q, resp_fault_d;

  logic        push, pop, empty, mem_we;
  logic [31:0] h_pc, h_addr, h_wdata;
  logic        h_store, h_fwd, h_fault;

  assign req_ready  = (count_q != (PW+1)'(DEPTH));
  assign push       = req_valid && req_ready;
  assign empty      = (count_q == '0);
  assign h_pc       = fifo_pc[rd_ptr_q];
  assign h_addr     = fifo_addr[rd_ptr_q];
  assign h_wdata    = fifo_wdata[rd_ptr_q];
  assign h_store    = fifo_store[rd_ptr_q];
  assign h_fwd      = fifo_fwd[rd_ptr_q];
  assign h_fault    = (h_addr[1:0] != 2'b00) ||
                      (h_addr[31:2] >= 30'(MEM_WORDS));
  assign resp_valid = (state_q == RESP);
  assign resp_pc    = resp_pc_q;
  assign resp_data  = resp_data_q;
  assign resp_store = resp_store_q;
  assign resp_fault = resp_fault_q;

  // Sequencer: pop head, run the RAM access, load completion outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_pc_d     = cur_pc_q;
    cur_idx_d    = cur_idx_q;
    cur_store_d  = cur_store_q;
    cur_wdata_d  = cur_wdata_q;
    resp_pc_d    = resp_pc_q;
    resp_data_d  = resp_data_q;
    resp_store_d = resp_store_q;
    resp_fault_d = resp_fault_q;
    pop          = 1'b0;
    mem_we       = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (h_fwd) begin
            state_d      = RESP;
            resp_pc_d    = h_pc;
            resp_data_d  = h_wdata;
            resp_store_d = h_store;
            resp_fault_d = 1'b0;
          end else if (h_fault) begin
            state_d      = RESP;
            resp_pc_d    = h_pc;
            resp_data_d  = '0;
            resp_store_d = h_store;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = CW'(LAT - 1);
            cur_pc_d    = h_pc;
            cur_idx_d   = h_addr[AW+1:2];
            cur_store_d = h_store;
            cur_wdata_d = h_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          mem_we       = cur_store_q;
          resp_pc_d    = cur_pc_q;
          resp_data_d  = cur_store_q ? 32'd0 : mem[cur_idx_q];
          resp_store_d = cur_store_q;
          resp_fault_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  // Control and completion registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_pc_q     <= '0;
      cur_idx_q    <= '0;
      cur_store_q  <= 1'b0;
      cur_wdata_q  <= '0;
      resp_pc_q    <= '0;
      resp_data_q  <= '0;
      resp_store_q <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_pc_q     <= cur_pc_d;
      cur_idx_q    <= cur_idx_d;
      cur_store_q  <= cur_store_d;
      cur_wdata_q  <= cur_wdata_d;
      resp_pc_q    <= resp_pc_d;
      resp_data_q  <= resp_data_d;
      resp_store_q <= resp_store_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // FIFO payload storage; entries are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      fifo_pc[wr_ptr_q]    <= req_pc;
      fifo_addr[wr_ptr_q]  <= req_addr;
      fifo_wdata[wr_ptr_q] <= req_wdata;
      fifo_store[wr_ptr_q] <= req_store;
      fifo_fwd[wr_ptr_q]   <= req_fwd;
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && mem_we) begin
      mem[cur_idx_q] <= cur_wdata_q;
    end
  end

endmodule

// File: tb/tb_lsq_mem_stage.sv
// Bench for lsq_mem_stage: directed steps plus random traffic,
// checked against an in-order completion model with a shadow RAM.
module tb_lsq_mem_stage;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic [31:0] req_addr = '0;
  logic        req_store = 1'b0;
  logic        req_fwd = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_data;
  logic        resp_store;
  logic        resp_fault;

  lsq_mem_stage #(.DEPTH(4), .MEM_WORDS(256), .LAT(2)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_addr(req_addr),
    .req_store(req_store), .req_fwd(req_fwd),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_pc(resp_pc),
    .resp_data(resp_data), .resp_store(resp_store),
    .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        store;
    logic        fwd;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] ram_m [256];
  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  int last_cyc = 0;
  int acc_cyc = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Completion monitor: every pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rstn && resp_valid) begin
      req_t r;
      logic [31:0] ed;
      logic ef, bad;
      resp_cnt++;
      last_cyc = cyc;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL resp_extra: got pc %h expected no response", resp_pc);
      end
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        bad = (r.addr % 4 != 0) || (r.addr / 4 >= 256);
        ed = 32'd0;
        ef = 1'b0;
        if (r.fwd) ed = r.wdata;
        else if (bad) ef = 1'b1;
        else if (r.store) ram_m[r.addr / 4] = r.wdata;
        else ed = ram_m[r.addr / 4];
        chk("resp_pc", resp_pc, r.pc);
        chk("resp_data", resp_data, ed);
        chk("resp_store", {31'd0, resp_store}, {31'd0, r.store});
        chk("resp_fault", {31'd0, resp_fault}, {31'd0, ef});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] addr,
                      input logic st, input logic fw,
                      input logic [31:0] wd);
    int w = 0;
    req_valid = 1'b1;
    req_pc = pc;
    req_addr = addr;
    req_store = st;
    req_fwd = fw;
    req_wdata = wd;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    exp_q.push_back('{pc: pc, addr: addr, wdata: wd, store: st, fwd: fw});
    tick();
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int w = 0;
    while (resp_cnt == n && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) chk("resp_timeout", resp_cnt, n + 1);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      tick();
      w++;
    end
    if (w == 400) chk("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int n;
    int acc;
    int w;
    bit saw;
    logic [31:0] a;
    rstn = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_pc", resp_pc, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_store", {31'd0, resp_store}, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) send(32'h1000 + i * 4, i * 4, 1'b1, 1'b0, $urandom);
    drain();

    n = resp_cnt;
    send(32'h4, 32'h10, 1'b1, 1'b0, 32'hDEADBEEF);
    wait_resp(n);
    chk("st_lat", last_cyc, acc_cyc + 3);
    chk("st_flag", {31'd0, resp_store}, 32'd1);
    chk("st_data", resp_data, 32'd0);
    n = resp_cnt;
    send(32'h8, 32'h10, 1'b0, 1'b0, 32'h0);
    wait_resp(n);
    chk("ld_lat", last_cyc, acc_cyc + 3);
    chk("ld_data", resp_data, 32'hDEADBEEF);

    n = resp_cnt;
    send(32'hC, 32'h20, 1'b0, 1'b1, 32'h55);
    wait_resp(n);
    chk("fwd_lat", last_cyc, acc_cyc + 1);
    chk("fwd_data", resp_data, 32'h55);
    n = resp_cnt;
    send(32'h10, 32'h20, 1'b0, 1'b0, 32'h0);
    wait_resp(n);
    chk("fwd_nowrite", resp_data, ram_m[8]);

    n = resp_cnt;
    send(32'h14, 32'h13, 1'b1, 1'b0, 32'h12345678);
    wait_resp(n);
    chk("mis_lat", last_cyc, acc_cyc + 1);
    chk("mis_fault", {31'd0, resp_fault}, 32'd1);
    chk("mis_data", resp_data, 32'd0);
    n = resp_cnt;
    send(32'h18, 32'h10, 1'b0, 1'b0, 32'h0);
    wait_resp(n);
    chk("mis_nowrite", resp_data, 32'hDEADBEEF);
    n = resp_cnt;
    send(32'h1C, 32'h400, 1'b0, 1'b0, 32'h0);
    wait_resp(n);
    chk("oor_fault", {31'd0, resp_fault}, 32'd1);
    drain();

    n = resp_cnt;
    send(32'h1FC, 32'h4, 1'b0, 1'b0, 32'h0);
    acc = 0;
    w = 0;
    saw = 1'b0;
    while (acc < 6 && w < 100) begin
      req_valid = 1'b1;
      req_pc = 32'h200 + acc * 4;
      req_addr = (acc % 4) * 4;
      req_store = acc[0];
      req_fwd = 1'b0;
      req_wdata = 32'hA000 + acc;
      if (req_ready) begin
        exp_q.push_back('{pc: req_pc, addr: req_addr, wdata: req_wdata,
                          store: req_store, fwd: 1'b0});
        acc++;
      end else begin
        saw = 1'b1;
      end
      tick();
      w++;
    end
    req_valid = 1'b0;
    chk("burst_accepted", acc, 6);
    chk("burst_backpressure", {31'd0, saw}, 32'd1);
    drain();
    chk("burst_count", resp_cnt - n, 7);

    send(32'h300, 32'h30, 1'b1, 1'b0, 32'h1111);
    drain();
    n = resp_cnt;
    send(32'h304, 32'h30, 1'b1, 1'b0, 32'h2222);
    tick();
    rstn = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("rst_mid_noresp", resp_cnt, n);
    n = resp_cnt;
    send(32'h308, 32'h30, 1'b0, 1'b0, 32'h0);
    wait_resp(n);
    chk("rst_mid_nowrite", resp_data, 32'h1111);
    drain();

    n = resp_cnt;
    for (int i = 0; i < 60; i++) begin
      int k;
      logic st;
      logic fw;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 15) * 4;
      if (k == 7) a = a | 32'($urandom_range(1, 3));
      if (k == 8) a = 32'h400 + $urandom_range(0, 255) * 4;
      st = 1'($urandom_range(0, 1));
      fw = !st && ($urandom_range(0, 3) == 0);
      send(32'h4000 + i * 4, a, st, fw, $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("rand_count", resp_cnt - n, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
